// File: rtl/ex_muldiv_iter.sv
`default_nettype none
// ============================================================================
// Module   : ex_muldiv_iter
// Purpose  : Radix-2 iterative multiply / multiply-accumulate / divide engine
//            for the EX stage (MULT(U), MADD(U), MSUB(U), DIV(U)).
// Revision : 1.0 - initial release
// ============================================================================
module ex_muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic                 annul_i,
  input  logic [2:0]           op_i,
  input  logic [WIDTH-1:0]     opdata1_i,
  input  logic [WIDTH-1:0]     opdata2_i,
  input  logic [2*WIDTH-1:0]   acc_i,
  output logic [2*WIDTH-1:0]   result_o,
  output logic                 ready_o,
  output logic                 busy_o,
  output logic                 div_zero_o
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_calc = 2'd1;
  localparam logic [1:0] c_st_fix  = 2'd2;
  localparam logic [1:0] c_st_done = 2'd3;

  localparam logic [1:0] c_kind_mul  = 2'd0;
  localparam logic [1:0] c_kind_madd = 2'd1;
  localparam logic [1:0] c_kind_msub = 2'd2;
  localparam logic [1:0] c_kind_div  = 2'd3;

  logic [1:0]           r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [1:0]           r_kind;
  logic                 r_sign_a;
  logic                 r_sign_b;
  logic                 r_div_zero;
  logic [WIDTH-1:0]     r_oper;
  logic [2*WIDTH-1:0]   r_work;
  logic [2*WIDTH-1:0]   r_acc;
  logic [2*WIDTH-1:0]   r_result;

  // Operand decode at accept: signed ops are the even encodings.
  logic                 w_signed;
  logic [1:0]           w_kind;
  logic                 w_sa;
  logic                 w_sb;
  logic [WIDTH-1:0]     w_mag_a;
  logic [WIDTH-1:0]     w_mag_b;
  logic                 w_accept;

  assign w_signed = ~op_i[0];
  assign w_kind   = op_i[2:1];
  assign w_sa     = w_signed & opdata1_i[WIDTH-1];
  assign w_sb     = w_signed & opdata2_i[WIDTH-1];
  assign w_mag_a  = w_sa ? -opdata1_i : opdata1_i;
  assign w_mag_b  = w_sb ? -opdata2_i : opdata2_i;
  assign w_accept = start_i & ~annul_i;

  // Multiply step: r_work = {partial product, remaining multiplier bits}.
  logic [WIDTH:0]       w_mul_sum;
  logic [2*WIDTH-1:0]   w_mul_next;

  assign w_mul_sum  = {1'b0, r_work[2*WIDTH-1:WIDTH]} +
                      (r_work[0] ? {1'b0, r_oper} : {(WIDTH+1){1'b0}});
  assign w_mul_next = {w_mul_sum, r_work[WIDTH-1:1]};

  // Restoring divide step: r_work = {remainder, dividend/quotient bits}.
  logic [WIDTH:0]       w_div_top;
  logic [WIDTH:0]       w_div_diff;
  logic                 w_div_ge;
  logic [2*WIDTH-1:0]   w_div_next;

  assign w_div_top  = r_work[2*WIDTH-1:WIDTH-1];
  assign w_div_diff = w_div_top - {1'b0, r_oper};
  assign w_div_ge   = ~w_div_diff[WIDTH];
  assign w_div_next = {(w_div_ge ? w_div_diff[WIDTH-1:0] : w_div_top[WIDTH-1:0]),
                       r_work[WIDTH-2:0], w_div_ge};

  // Sign correction and accumulate, evaluated during FIX.
  logic                 w_neg;
  logic [2*WIDTH-1:0]   w_prod;
  logic [WIDTH-1:0]     w_quo;
  logic [WIDTH-1:0]     w_rem;
  logic [2*WIDTH-1:0]   w_fix;

  assign w_neg  = r_sign_a ^ r_sign_b;
  assign w_prod = w_neg ? -r_work : r_work;
  assign w_quo  = w_neg ? -r_work[WIDTH-1:0] : r_work[WIDTH-1:0];
  assign w_rem  = r_sign_a ? -r_work[2*WIDTH-1:WIDTH] : r_work[2*WIDTH-1:WIDTH];

  always_comb begin
    w_fix = w_prod;
    case (r_kind)
      c_kind_mul:  w_fix = w_prod;
      c_kind_madd: w_fix = r_acc + w_prod;
      c_kind_msub: w_fix = r_acc - w_prod;
      c_kind_div:  w_fix = {w_rem, w_quo};
      default:     w_fix = w_prod;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= c_st_idle;
      r_cnt      <= '0;
      r_kind     <= '0;
      r_sign_a   <= 1'b0;
      r_sign_b   <= 1'b0;
      r_div_zero <= 1'b0;
      r_oper     <= '0;
      r_work     <= '0;
      r_acc      <= '0;
      r_result   <= '0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (w_accept) begin
            r_kind     <= w_kind;
            r_sign_a   <= w_sa;
            r_sign_b   <= w_sb;
            r_acc      <= acc_i;
            r_cnt      <= '0;
            r_div_zero <= 1'b0;
            if (w_kind == c_kind_div) begin
              r_oper <= w_mag_b;
              r_work <= {{WIDTH{1'b0}}, w_mag_a};
              if (opdata2_i == '0) begin
                r_div_zero <= 1'b1;
                r_result   <= '0;
                r_state    <= c_st_done;
              end else begin
                r_state    <= c_st_calc;
              end
            end else begin
              r_oper  <= w_mag_a;
              r_work  <= {{WIDTH{1'b0}}, w_mag_b};
              r_state <= c_st_calc;
            end
          end
        end
        c_st_calc: begin
          if (annul_i) begin
            r_state <= c_st_idle;
          end else begin
            r_work <= (r_kind == c_kind_div) ? w_div_next : w_mul_next;
            r_cnt  <= r_cnt + 1'b1;
            if (r_cnt == CNT_W'(WIDTH - 1)) begin
              r_state <= c_st_fix;
            end
          end
        end
        c_st_fix: begin
          if (annul_i) begin
            r_state <= c_st_idle;
          end else begin
            r_result <= w_fix;
            r_state  <= c_st_done;
          end
        end
        default: begin
          r_state <= c_st_idle;
        end
      endcase
    end
  end

  // A flush in DONE suppresses the pulse in that same cycle.
  assign ready_o    = (r_state == c_st_done) & ~annul_i;
  assign div_zero_o = ready_o & r_div_zero;
  assign busy_o     = (r_state != c_st_idle);
  assign result_o   = r_result;

endmodule
`default_nettype wire

// File: tb/tb_ex_muldiv_iter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_muldiv_iter
// Purpose  : Randomised self-checking bench for ex_muldiv_iter against a
//            plain-arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ex_muldiv_iter;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_i;
  logic          annul_i;
  logic [2:0]    op_i;
  logic [W-1:0]  opdata1_i;
  logic [W-1:0]  opdata2_i;
  logic [2*W-1:0] acc_i;
  logic [2*W-1:0] result_o;
  logic          ready_o;
  logic          busy_o;
  logic          div_zero_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ex_muldiv_iter #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .annul_i    (annul_i),
    .op_i       (op_i),
    .opdata1_i  (opdata1_i),
    .opdata2_i  (opdata2_i),
    .acc_i      (acc_i),
    .result_o   (result_o),
    .ready_o    (ready_o),
    .busy_o     (busy_o),
    .div_zero_o (div_zero_o)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Returns {div_zero, result}.
  function automatic logic [64:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [63:0] acc);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p  = 64'd0;
    if (op[2:1] == 2'b11) begin
      if (b == 32'd0) return {1'b1, 64'd0};
      if (op[0] == 1'b0) begin
        q = sa / sb;
        r = sa % sb;
        return {1'b0, r[31:0], q[31:0]};
      end
      return {1'b0, a % b, a / b};
    end
    if (op[0] == 1'b0) p = 64'(sa * sb);
    else               p = {32'd0, a} * {32'd0, b};
    case (op[2:1])
      2'b01:   return {1'b0, acc + p};
      2'b10:   return {1'b0, acc - p};
      default: return {1'b0, p};
    endcase
  endfunction

  // Issue one op and follow it to completion. With now=1 the request is
  // driven in the current cycle instead of waiting for the next negedge.
  task automatic run_op(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                        input logic [63:0] ac, input bit now, input string tag);
    logic [64:0] exp;
    int lat, n, busy_bad;
    exp = model(op, x, y, ac);
    lat = exp[64] ? 1 : W + 2;
    if (!now) @(negedge clk);
    op_i = op; opdata1_i = x; opdata2_i = y; acc_i = ac; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    op_i = 3'($urandom); opdata1_i = $urandom; opdata2_i = $urandom; acc_i = {$urandom, $urandom};
    n = 1; busy_bad = 0;
    while (!ready_o && n < 100) begin
      if (!busy_o) busy_bad++;
      start_i = (n < W) ? 1'($urandom_range(0, 1)) : 1'b0;
      @(posedge clk); #1;
      n++;
    end
    start_i = 1'b0;
    check({tag, "_lat"}, n, lat);
    check({tag, "_res"}, result_o, exp[63:0]);
    check({tag, "_dz"}, div_zero_o, exp[64]);
    check({tag, "_busy"}, {busy_bad, 31'd0, busy_o}, 64'd1);
    @(posedge clk); #1;
    check({tag, "_idle"}, {ready_o, busy_o, div_zero_o}, 3'b000);
    check({tag, "_hold"}, result_o, exp[63:0]);
  endtask

  // Start an op and flush it at cycle k+at.
  task automatic annul_op(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                          input int at, input string tag);
    logic [63:0] prior;
    int n, seen;
    prior = result_o;
    @(negedge clk);
    op_i = op; opdata1_i = x; opdata2_i = y; acc_i = 64'd0; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    n = 1; seen = 0;
    while (n < at) begin
      if (ready_o) seen++;
      @(posedge clk); #1;
      n++;
    end
    annul_i = 1'b1;
    #1;
    if (ready_o) seen++;
    @(posedge clk); #1;
    annul_i = 1'b0;
    if (ready_o) seen++;
    check({tag, "_noready"}, seen, 0);
    check({tag, "_busy"}, busy_o, 1'b0);
    if (at <= W + 1) check({tag, "_keep"}, result_o, prior);
  endtask

  initial begin
    logic [2:0]  op;
    logic [31:0] x, y;
    rst = 1'b1; start_i = 1'b0; annul_i = 1'b0; op_i = 3'd0;
    opdata1_i = '0; opdata2_i = '0; acc_i = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset", {result_o, ready_o, busy_o, div_zero_o}, 67'd0);
    @(negedge clk); rst = 1'b0;

    run_op(3'd0, -32'sd3, 32'd5, 64'd0, 1'b0, "mult");
    run_op(3'd3, 32'hFFFF_FFFF, 32'd2, 64'd1, 1'b0, "maddu");
    run_op(3'd4, 32'd3, 32'd4, 64'd10, 1'b0, "msub");
    run_op(3'd6, -32'sd7, 32'd2, 64'd0, 1'b0, "div");
    run_op(3'd7, 32'd100, 32'd7, 64'd0, 1'b0, "divu");
    run_op(3'd7, 32'd5, 32'd0, 64'd0, 1'b0, "divu0");
    run_op(3'd1, 32'd9, 32'd9, 64'd0, 1'b0, "after0");
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 64'd0, 1'b0, "divovf");

    annul_op(3'd1, 32'd123, 32'd456, 10, "annul10");
    run_op(3'd7, 32'd100, 32'd7, 64'd0, 1'b1, "restart");
    annul_op(3'd2, 32'd7, 32'd7, W + 1, "annulfix");
    annul_op(3'd0, 32'd5, 32'd6, W + 2, "annuldone");

    @(negedge clk); start_i = 1'b1; annul_i = 1'b1;
    @(posedge clk); #1;
    check("annul_start", busy_o, 1'b0);
    start_i = 1'b0; annul_i = 1'b0;

    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom);
      x = $urandom; y = $urandom;
      case ($urandom_range(0, 5))
        0: y = 32'd0;
        1: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
        2: begin x = $urandom_range(0, 20); y = $urandom_range(1, 20); end
        default: ;
      endcase
      run_op(op, x, y, {$urandom, $urandom}, 1'b0, $sformatf("rnd%0d", i));
    end

    @(negedge clk);
    op_i = 3'd1; opdata1_i = 32'd3; opdata2_i = 32'd3; start_i = 1'b1;
    @(posedge clk); #1; start_i = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check("midrst", {result_o, ready_o, busy_o, div_zero_o}, 67'd0);
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
